// File: rtl/fp_mult_pkg.sv
// Shared types and constants for the shared FP multiplier arbiter.
// Bench checkers import the same special-value encodings.
package fp_mult_pkg;

  localparam int FP_W   = 32;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;

  localparam logic [FP_W-1:0] QNAN    = 32'h7FC0_0000;
  localparam logic [FP_W-1:0] POS_INF = 32'h7F80_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fp_mult_arbiter_rr_arbiter.sv
// Round-robin grant: first asserted request at or above ptr, wrapping.
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IW-1:0]    idx_o,
  output logic             any_o
);

  int          j;
  logic [IW-1:0] jj;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    jj    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N_REQ) j = j - N_REQ;
      jj = IW'(j);
      if (!any_o && req_i[jj]) begin
        any_o     = 1'b1;
        gnt_o[jj] = 1'b1;
        idx_o     = jj;
      end
    end
  end

endmodule

// File: rtl/fp_multiplier.sv
// Combinational IEEE-754 single multiply, round-to-nearest-even.
// Subnormal inputs and results are flushed to signed zero.
module fp_multiplier
  import fp_mult_pkg::*;
(
  input  logic [FP_W-1:0] a_i,
  input  logic [FP_W-1:0] b_i,
  output logic [FP_W-1:0] p_o
);

  logic              s;
  logic [EXP_W-1:0]  ea, eb;
  logic [FRAC_W-1:0] fa, fb, man;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [47:0]       prod;
  logic              g, st;
  logic [24:0]       rnd;
  logic [9:0]        exp_raw, exp_r;
  logic [FRAC_W-1:0] frac;

  always_comb begin
    s      = a_i[FP_W-1] ^ b_i[FP_W-1];
    ea     = a_i[FP_W-2 -: EXP_W];
    eb     = b_i[FP_W-2 -: EXP_W];
    fa     = a_i[FRAC_W-1:0];
    fb     = b_i[FRAC_W-1:0];
    a_nan  = (&ea) & (|fa);
    b_nan  = (&eb) & (|fb);
    a_inf  = (&ea) & ~(|fa);
    b_inf  = (&eb) & ~(|fb);
    a_zero = ~(|ea);
    b_zero = ~(|eb);
    prod   = 48'({1'b1, fa}) * 48'({1'b1, fb});
    if (prod[47]) begin
      man = prod[46:24];
      g   = prod[23];
      st  = |prod[22:0];
    end else begin
      man = prod[45:23];
      g   = prod[22];
      st  = |prod[21:0];
    end
    rnd     = {2'b01, man} + 25'(g & (st | man[0]));
    exp_raw = {2'b00, ea} + {2'b00, eb} - 10'd127
            + {9'd0, prod[47]};
    exp_r   = rnd[24] ? exp_raw + 10'd1 : exp_raw;
    frac    = rnd[24] ? rnd[23:1] : rnd[22:0];

    if (a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf))
      p_o = QNAN;
    else if (a_inf | b_inf)
      p_o = POS_INF | {s, 31'd0};
    else if (a_zero | b_zero)
      p_o = {s, 31'd0};
    else if ($signed(exp_r) >= 10'sd255)
      p_o = POS_INF | {s, 31'd0};
    else if ($signed(exp_r) <= 10'sd0)
      p_o = {s, 31'd0};
    else
      p_o = {s, exp_r[7:0], frac};
  end

endmodule

// File: rtl/fp_mult_arbiter.sv
// Shares one combinational FP multiplier among N_REQ requesters,
// returning tagged products after LAT cycles on a valid/ready port.
module fp_mult_arbiter
  import fp_mult_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int LAT   = 2,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [32*N_REQ-1:0] req_a,
  input  logic [32*N_REQ-1:0] req_b,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [31:0]        res_data,
  output logic [IW-1:0]      res_id,
  output logic               busy
);

  localparam logic [3:0] CNT_INIT =
    (LAT >= 2) ? 4'(LAT - 2) : 4'd0;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] id_q, id_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [31:0]   res_q, res_d;

  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]    gidx;
  logic             any, accept, fire;
  logic [31:0]      sel_a, sel_b;
  logic [31:0]      mul_a, mul_b, mul_p;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gidx),
    .any_o (any)
  );

  // With LAT==1 the product is captured on the accept edge itself.
  assign sel_a = req_a[int'(gidx)*FP_W +: FP_W];
  assign sel_b = req_b[int'(gidx)*FP_W +: FP_W];
  assign mul_a = (LAT == 1) ? sel_a : a_q;
  assign mul_b = (LAT == 1) ? sel_b : b_q;

  fp_multiplier u_mul (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (mul_p)
  );

  assign accept = rst_n & ((state_q == IDLE) |
                  ((state_q == DONE) & res_ready));
  assign fire      = accept & any;
  assign req_ready = fire ? gnt : '0;
  assign res_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign res_data  = res_q;
  assign res_id    = id_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: ;
      EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          res_d   = mul_p;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (res_ready && !any) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (fire) begin
      a_d   = sel_a;
      b_d   = sel_b;
      id_d  = gidx;
      ptr_d = (int'(gidx) == N_REQ - 1) ? '0 : gidx + 1'b1;
      cnt_d = CNT_INIT;
      if (LAT == 1) begin
        state_d = DONE;
        res_d   = mul_p;
      end else begin
        state_d = EXEC;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

endmodule
